// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath definitions: ALU codes, aluOp encodings, funct values
// and default widths. These are the same constants that alu_32_bit uses.
package mips_defs_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_code_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/alu_control.sv
// Combinational aluOp/funct decode into the 4-bit ALU code plus an illegal flag.
// Unsupported encodings fall back to ADD so the ALU still sees a defined code.
module alu_control
    import mips_defs_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_code,
    output logic       illegal
);

    always_comb begin
        alu_code = ALU_ADD;
        illegal  = 1'b0;
        case (alu_op_e'(alu_op))
            ALUOP_ADD: alu_code = ALU_ADD;
            ALUOP_SUB: alu_code = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_code = ALU_ADD;
                    FUNCT_SUB: alu_code = ALU_SUB;
                    FUNCT_AND: alu_code = ALU_AND;
                    FUNCT_OR:  alu_code = ALU_OR;
                    FUNCT_SLT: alu_code = ALU_SLT;
                    default:   illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding alu_32_bit: ALU decode, ALUSrc mux and
// immediate sign-extension, with stall (hold) and flush (bubble) controls.
module id_ex_stage
    import mips_defs_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [15:0]           id_imm,
    input  logic [5:0]            id_funct,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_branch,
    output logic                  ex_valid,
    output logic [3:0]            ex_alu_code,
    output logic [DATA_W-1:0]     ex_a,
    output logic [DATA_W-1:0]     ex_b,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_wr_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_branch,
    output logic                  ex_illegal
);

    logic [3:0]        dec_code;
    logic              dec_illegal;
    logic              load_illegal;
    logic [DATA_W-1:0] imm_ext;
    ctrl_t             load_ctrl;
    ctrl_t             ex_ctrl;

    alu_control u_alu_control (
        .alu_op   (id_alu_op),
        .funct    (id_funct),
        .alu_code (dec_code),
        .illegal  (dec_illegal)
    );

    assign imm_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};

    // An empty decode slot loads as a bubble; an illegal op keeps valid but
    // drops every control that would change architectural state.
    always_comb begin
        load_illegal = id_valid & dec_illegal;
        load_ctrl    = '0;
        if (id_valid) begin
            load_ctrl.reg_write  = id_reg_write & ~dec_illegal;
            load_ctrl.mem_read   = id_mem_read  & ~dec_illegal;
            load_ctrl.mem_write  = id_mem_write & ~dec_illegal;
            load_ctrl.mem_to_reg = id_mem_to_reg;
            load_ctrl.branch     = id_branch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_illegal    <= 1'b0;
            ex_ctrl       <= '0;
            ex_alu_code   <= '0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_wr_addr    <= '0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
            ex_ctrl    <= '0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_illegal    <= load_illegal;
            ex_ctrl       <= load_ctrl;
            ex_alu_code   <= dec_code;
            ex_a          <= id_rs_data;
            ex_b          <= id_alu_src ? imm_ext : id_rt_data;
            ex_store_data <= id_rt_data;
            ex_wr_addr    <= id_reg_dst ? id_rd_addr : id_rt_addr;
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_branch     = ex_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_reg_dst;
    logic [4:0]  id_rt_addr;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_mem_to_reg;
    logic        id_branch;

    logic        ex_valid;
    logic [3:0]  ex_alu_code;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wr_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_branch;
    logic        ex_illegal;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic        check_en = 1'b0;

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
        .id_funct      (id_funct),
        .id_alu_op     (id_alu_op),
        .id_alu_src    (id_alu_src),
        .id_reg_dst    (id_reg_dst),
        .id_rt_addr    (id_rt_addr),
        .id_rd_addr    (id_rd_addr),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_mem_to_reg (id_mem_to_reg),
        .id_branch     (id_branch),
        .ex_valid      (ex_valid),
        .ex_alu_code   (ex_alu_code),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_store_data (ex_store_data),
        .ex_wr_addr    (ex_wr_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_branch     (ex_branch),
        .ex_illegal    (ex_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the EX slot as a record of what the ALU should see.
    typedef struct {
        logic        valid;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
        logic [4:0]  wr;
        logic        rw, mr, mw, m2r, br, ill;
    } slot_t;

    slot_t m;

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                       output logic [3:0] code, output logic ill);
        code = 4'b0010;
        ill  = 1'b0;
        if (op == 2'b00)      code = 4'b0010;
        else if (op == 2'b01) code = 4'b0110;
        else if (op == 2'b11) ill  = 1'b1;
        else if (f == 6'b100000) code = 4'b0010;
        else if (f == 6'b100010) code = 4'b0110;
        else if (f == 6'b100100) code = 4'b0000;
        else if (f == 6'b100101) code = 4'b0001;
        else if (f == 6'b101010) code = 4'b0111;
        else ill = 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] c;
        logic       il;
        if (!rst_n) begin
            m = '{valid: 1'b0, code: 4'h0, a: 32'h0, b: 32'h0, store: 32'h0, wr: 5'h0,
                  rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, br: 1'b0, ill: 1'b0};
        end else if (flush) begin
            m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
            m.m2r = 1'b0; m.br = 1'b0; m.ill = 1'b0;
        end else if (!stall) begin
            ref_decode(id_alu_op, id_funct, c, il);
            m.code  = c;
            m.a     = id_rs_data;
            m.b     = id_alu_src ? 32'(signed'(id_imm)) : id_rt_data;
            m.store = id_rt_data;
            m.wr    = id_reg_dst ? id_rd_addr : id_rt_addr;
            m.valid = id_valid;
            m.ill   = id_valid && il;
            m.rw    = id_valid && !il && id_reg_write;
            m.mr    = id_valid && !il && id_mem_read;
            m.mw    = id_valid && !il && id_mem_write;
            m.m2r   = id_valid && id_mem_to_reg;
            m.br    = id_valid && id_branch;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_valid",   32'(ex_valid),      32'(m.valid));
            chk("cmp_code",    32'(ex_alu_code),   32'(m.code));
            chk("cmp_a",       ex_a,               m.a);
            chk("cmp_b",       ex_b,               m.b);
            chk("cmp_store",   ex_store_data,      m.store);
            chk("cmp_wr",      32'(ex_wr_addr),    32'(m.wr));
            chk("cmp_rw",      32'(ex_reg_write),  32'(m.rw));
            chk("cmp_mr",      32'(ex_mem_read),   32'(m.mr));
            chk("cmp_mw",      32'(ex_mem_write),  32'(m.mw));
            chk("cmp_m2r",     32'(ex_mem_to_reg), 32'(m.m2r));
            chk("cmp_br",      32'(ex_branch),     32'(m.br));
            chk("cmp_illegal", 32'(ex_illegal),    32'(m.ill));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 32'h0);
        chk({tag, "_code"},  32'(ex_alu_code), 32'h0);
        chk({tag, "_a"},     ex_a, 32'h0);
        chk({tag, "_b"},     ex_b, 32'h0);
        chk({tag, "_store"}, ex_store_data, 32'h0);
        chk({tag, "_wr"},    32'(ex_wr_addr), 32'h0);
        chk({tag, "_ctrl"},  32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}), 32'h0);
        chk({tag, "_ill"},   32'(ex_illegal), 32'h0);
    endtask

    task automatic randomize_id();
        logic [5:0] legal [5];
        legal[0] = 6'b100000; legal[1] = 6'b100010; legal[2] = 6'b100100;
        legal[3] = 6'b100101; legal[4] = 6'b101010;
        id_valid      = ($urandom_range(7) != 0);
        id_rs_data    = $urandom;
        id_rt_data    = $urandom;
        id_imm        = 16'($urandom);
        id_alu_op     = 2'($urandom);
        id_funct      = ($urandom_range(3) == 0) ? 6'($urandom) : legal[$urandom_range(4)];
        id_alu_src    = 1'($urandom);
        id_reg_dst    = 1'($urandom);
        id_rt_addr    = 5'($urandom);
        id_rd_addr    = 5'($urandom);
        id_reg_write  = 1'($urandom);
        id_mem_read   = 1'($urandom);
        id_mem_write  = 1'($urandom);
        id_mem_to_reg = 1'($urandom);
        id_branch     = 1'($urandom);
    endtask

    task automatic clear_id();
        id_valid = 1'b1; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_funct = '0; id_alu_op = '0; id_alu_src = 1'b0; id_reg_dst = 1'b0;
        id_rt_addr = '0; id_rd_addr = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_mem_write = 1'b0; id_mem_to_reg = 1'b0; id_branch = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        stall = 1'b0;
        flush = 1'b0;
        rst_n = 1'b1;
        randomize_id();
        #1 rst_n = 1'b0;
        #2;
        chk_all_zero("rst_async");
        step();
        chk_all_zero("rst_held");
        #5 rst_n = 1'b1;
        check_en = 1'b1;

        // R-type sub
        clear_id();
        id_alu_op = 2'b10; id_funct = 6'b100010;
        id_rs_data = -32'sd7; id_rt_data = 32'd6;
        id_reg_dst = 1'b1; id_rd_addr = 5'd9; id_reg_write = 1'b1;
        step();
        chk("sub_code",  32'(ex_alu_code), 32'h6);
        chk("sub_a",     ex_a, 32'hFFFF_FFF9);
        chk("sub_b",     ex_b, 32'd6);
        chk("sub_wr",    32'(ex_wr_addr), 32'd9);
        chk("sub_valid", 32'(ex_valid), 32'd1);

        // lw with negative immediate
        clear_id();
        id_alu_op = 2'b00; id_alu_src = 1'b1; id_imm = 16'hFFFC;
        id_rs_data = 32'd100; id_rt_data = 32'h1234_5678; id_rt_addr = 5'd4;
        id_rd_addr = 5'd17; id_mem_read = 1'b1;
        step();
        chk("lw_code",  32'(ex_alu_code), 32'h2);
        chk("lw_b",     ex_b, 32'hFFFF_FFFC);
        chk("lw_store", ex_store_data, 32'h1234_5678);
        chk("lw_wr",    32'(ex_wr_addr), 32'd4);
        chk("lw_mr",    32'(ex_mem_read), 32'd1);

        // slt, then stall for two cycles while the decode slot changes
        clear_id();
        id_alu_op = 2'b10; id_funct = 6'b101010; id_rs_data = 32'd55;
        id_reg_dst = 1'b1; id_rd_addr = 5'd3; id_reg_write = 1'b1;
        step();
        chk("slt_code", 32'(ex_alu_code), 32'h7);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            randomize_id();
            step();
            chk("stall_code", 32'(ex_alu_code), 32'h7);
            chk("stall_a",    ex_a, 32'd55);
            chk("stall_wr",   32'(ex_wr_addr), 32'd3);
            chk("stall_rw",   32'(ex_reg_write), 32'd1);
        end
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_rw",    32'(ex_reg_write), 32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // illegal funct suppresses side effects but stays valid
        clear_id();
        id_alu_op = 2'b10; id_funct = 6'b000111; id_reg_write = 1'b1; id_mem_write = 1'b1;
        step();
        chk("ill_flag",  32'(ex_illegal), 32'd1);
        chk("ill_code",  32'(ex_alu_code), 32'h2);
        chk("ill_rw",    32'(ex_reg_write), 32'd0);
        chk("ill_mw",    32'(ex_mem_write), 32'd0);
        chk("ill_valid", 32'(ex_valid), 32'd1);

        // empty decode slot
        clear_id();
        id_valid = 1'b0; id_reg_write = 1'b1;
        step();
        chk("nv_valid", 32'(ex_valid), 32'd0);
        chk("nv_rw",    32'(ex_reg_write), 32'd0);

        // beq
        clear_id();
        id_alu_op = 2'b01; id_rs_data = 32'd7; id_rt_data = 32'd7; id_branch = 1'b1;
        step();
        chk("beq_code", 32'(ex_alu_code), 32'h6);
        chk("beq_br",   32'(ex_branch), 32'd1);

        // reset asserted while stalled wins without a clock edge
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_stall");
        #2 rst_n = 1'b1;
        stall = 1'b0;
        step();

        for (int i = 0; i < 600; i++) begin
            randomize_id();
            stall = ($urandom_range(4) == 0);
            flush = ($urandom_range(7) == 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
